// File: rtl/pck_flit_injector_pkg.sv
// Shared NoC definitions for the packet-to-flit injector: flit layout,
// field widths, injector FSM states and the packet-size clamp.
package pck_flit_injector_pkg;

   localparam int Fpay       = 32;
   localparam int EAw        = 4;
   localparam int DAw        = 4;
   localparam int PCK_INJ_Dw = 64;
   localparam int NOC_V      = 4;
   localparam int PCK_SIZw   = 6;

   typedef struct packed {
      logic              hdr_flag;
      logic              tail_flag;
      logic [NOC_V-1:0]  vc;
      logic [Fpay-1:0]   payload;
   } flit_t;

   localparam int Fw = $bits(flit_t);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      BODY = 2'd2
   } inj_state_e;

   // A zero-length request still produces one (header+tail) flit.
   function automatic logic [PCK_SIZw-1:0] clamp_pck_size(input logic [PCK_SIZw-1:0] siz,
                                                           input int max_siz);
      if (siz == '0)
         return PCK_SIZw'(1);
      else if (int'(siz) > max_siz)
         return PCK_SIZw'(max_siz);
      else
         return siz;
   endfunction

endpackage

// File: rtl/pck_flit_injector_if.sv
// Packet-request and flit/credit bundle between a packet source and the injector.
interface pck_flit_injector_if #(
   parameter int V = 4,
   parameter int B = 4
);
   import pck_flit_injector_pkg::*;

   localparam int CW = $clog2(B + 1);

   // Request handshake: a request on VC v transfers in a cycle where pck_wr=1,
   // pck_vc is one-hot with bit v set and ready[v]=1; otherwise it is dropped.
   logic [EAw-1:0]        src_e_addr;
   logic                  pck_wr;
   logic [V-1:0]          pck_vc;
   logic [PCK_SIZw-1:0]   pck_size;
   logic [DAw-1:0]        pck_dest;
   logic [PCK_INJ_Dw-1:0] pck_data;
   logic [V-1:0]          ready;
   logic                  flit_wr;
   flit_t                 flit_out;
   logic [V-1:0]          credit_in;
   logic                  busy;
   inj_state_e            dbg_state;
   logic [V-1:0][CW-1:0]  dbg_credit;

   modport slave (
      input  src_e_addr, pck_wr, pck_vc, pck_size, pck_dest, pck_data, credit_in,
      output ready, flit_wr, flit_out, busy, dbg_state, dbg_credit
   );

   modport master (
      output src_e_addr, pck_wr, pck_vc, pck_size, pck_dest, pck_data, credit_in,
      input  ready, flit_wr, flit_out, busy, dbg_state, dbg_credit
   );

endinterface

// File: rtl/pck_flit_injector_credit_cnt.sv
// Per-VC credit counter: starts full at B, one credit per sent flit, one back per credit_in.
module injector_credit_cnt #(
   parameter int B  = 4,
   parameter int CW = $clog2(B + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          inc,
   input  logic          dec,
   output logic [CW-1:0] count
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= CW'(B);
      end else if (inc && !dec) begin
         if (count != CW'(B))
            count <= count + CW'(1);
      end else if (dec && !inc) begin
         if (count != '0)
            count <= count - CW'(1);
      end
   end

   // Returning more credits than buffers, or sending without one, is an upstream bug.
   credit_range : assert property (@(posedge clk) disable iff (!reset)
      !((inc && !dec && count == CW'(B)) || (dec && !inc && count == '0)));

endmodule

// File: rtl/pck_flit_injector.sv
// Splits one packet request into header and body flits, pacing them by per-VC
// credits from the router's local input buffers.
module pck_flit_injector
   import pck_flit_injector_pkg::*;
#(
   parameter int V           = 4,
   parameter int B           = 4,
   parameter int MAX_PCK_SIZ = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   pck_flit_injector_if.slave   bus
);

   localparam int CW = $clog2(B + 1);

   inj_state_e            state, state_next;
   logic [V-1:0]          cur_vc;
   logic [DAw-1:0]        cur_dest;
   logic [PCK_INJ_Dw-1:0] cur_data;
   logic [PCK_SIZw-1:0]   cur_size;
   logic [PCK_SIZw-1:0]   idx;
   logic [V-1:0][CW-1:0]  credit;
   logic [V-1:0]          credit_nz;
   logic [V-1:0]          dec;
   logic [V-1:0]          ready_int;
   logic                  vc_onehot;
   logic                  accept;
   logic                  can_send;
   logic                  send;
   logic                  tail;
   flit_t                 flit_next, flit_q;
   logic                  flit_wr_q;
   int                    rot_amt;
   logic [Fpay-1:0]       hdr_payload;
   logic [Fpay-1:0]       body_payload;

   for (genvar v = 0; v < V; v++) begin : g_credit
      injector_credit_cnt #(.B(B), .CW(CW)) u_cnt (
         .clk   (clk),
         .reset (reset),
         .inc   (bus.credit_in[v]),
         .dec   (dec[v]),
         .count (credit[v])
      );
      assign credit_nz[v] = (credit[v] != '0);
      assign dec[v]       = send & cur_vc[v];
   end

   assign ready_int = {V{state == IDLE}} & credit_nz;
   assign vc_onehot = (bus.pck_vc != '0) && ((bus.pck_vc & (bus.pck_vc - V'(1))) == '0);
   assign accept    = bus.pck_wr && vc_onehot && ((bus.pck_vc & ready_int) != '0);

   // A credit arriving this cycle already counts toward sending this cycle.
   assign can_send = ((cur_vc & (credit_nz | bus.credit_in)) != '0);

   assign hdr_payload  = Fpay'({cur_data, cur_dest, bus.src_e_addr});
   assign rot_amt      = (Fpay * int'(idx)) % PCK_INJ_Dw;
   assign body_payload = Fpay'({cur_data, cur_data} >> rot_amt);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      send       = 1'b0;
      tail       = 1'b0;
      flit_next  = flit_q;
      case (state)
         IDLE: begin
            if (accept)
               state_next = HDR;
         end
         HDR: begin
            if (can_send) begin
               send                = 1'b1;
               tail                = (cur_size == PCK_SIZw'(1));
               flit_next.hdr_flag  = 1'b1;
               flit_next.tail_flag = tail;
               flit_next.vc        = NOC_V'(cur_vc);
               flit_next.payload   = hdr_payload;
               state_next          = tail ? IDLE : BODY;
            end
         end
         BODY: begin
            if (can_send) begin
               send                = 1'b1;
               tail                = (idx == cur_size - PCK_SIZw'(1));
               flit_next.hdr_flag  = 1'b0;
               flit_next.tail_flag = tail;
               flit_next.vc        = NOC_V'(cur_vc);
               flit_next.payload   = body_payload;
               if (tail)
                  state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // idx is the number of the flit about to be sent; the header is flit 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flit_wr_q <= 1'b0;
         flit_q    <= '0;
         idx       <= '0;
         cur_vc    <= '0;
         cur_dest  <= '0;
         cur_data  <= '0;
         cur_size  <= '0;
      end else begin
         flit_wr_q <= send;
         if (send)
            flit_q <= flit_next;
         if (accept) begin
            cur_vc   <= bus.pck_vc;
            cur_dest <= bus.pck_dest;
            cur_data <= bus.pck_data;
            cur_size <= clamp_pck_size(bus.pck_size, MAX_PCK_SIZ);
            idx      <= '0;
         end else if (send) begin
            idx <= tail ? '0 : idx + PCK_SIZw'(1);
         end
      end
   end

   assign bus.ready      = ready_int;
   assign bus.flit_wr    = flit_wr_q;
   assign bus.flit_out   = flit_q;
   assign bus.busy       = (state != IDLE);
   assign bus.dbg_state  = state;
   assign bus.dbg_credit = credit;

endmodule

// File: tb/tb_pck_flit_injector.sv
// Directed scenarios for pck_flit_injector with hand-computed flits and credits.
module tb_pck_flit_injector;
   import pck_flit_injector_pkg::*;

   localparam int V   = 4;
   localparam int B   = 4;
   localparam int MAX = 16;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pck_flit_injector_if #(.V(V), .B(B)) bus ();

   pck_flit_injector #(.V(V), .B(B), .MAX_PCK_SIZ(MAX)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic idle_inputs();
      bus.src_e_addr = 4'hA;
      bus.pck_wr     = 1'b0;
      bus.pck_vc     = '0;
      bus.pck_size   = '0;
      bus.pck_dest   = '0;
      bus.pck_data   = '0;
      bus.credit_in  = '0;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send_req(input logic [3:0] vc, input logic [5:0] size,
                           input logic [3:0] dest, input logic [63:0] data);
      bus.pck_wr   = 1'b1;
      bus.pck_vc   = vc;
      bus.pck_size = size;
      bus.pck_dest = dest;
      bus.pck_data = data;
      @(negedge clk);
      bus.pck_wr   = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle_inputs();
      @(negedge clk);
      checks++;
      if (bus.flit_wr !== 1'b0 || bus.flit_out !== '0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: flit_wr=%b flit_out=%h busy=%b, required 0/0/0",
                  bus.flit_wr, bus.flit_out, bus.busy);
      end
      checks++;
      if (bus.dbg_state !== IDLE) begin
         errors++;
         $display("FAIL reset_state: got %0d, required IDLE", bus.dbg_state);
      end
      for (int v = 0; v < V; v++) begin
         checks++;
         if (bus.dbg_credit[v] !== 3'd4) begin
            errors++;
            $display("FAIL reset_credit[%0d]: got %0d, required 4", v, bus.dbg_credit[v]);
         end
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.ready !== 4'b1111) begin
         errors++;
         $display("FAIL reset_ready: got %b, required 1111", bus.ready);
      end
   endtask

   task automatic test_single_flit();
      flit_t exp;
      apply_reset();
      send_req(4'b0001, 6'd1, 4'h5, 64'h0123_4567_89AB_CDEF);
      checks++;
      if (bus.busy !== 1'b1 || bus.ready !== 4'b0000 || bus.flit_wr !== 1'b0) begin
         errors++;
         $display("FAIL single_hdr_wait: busy=%b ready=%b flit_wr=%b, required 1/0000/0",
                  bus.busy, bus.ready, bus.flit_wr);
      end
      @(negedge clk);
      exp = '{hdr_flag: 1'b1, tail_flag: 1'b1, vc: 4'b0001, payload: 32'hABCD_EF5A};
      checks++;
      if (bus.flit_wr !== 1'b1 || bus.flit_out !== exp) begin
         errors++;
         $display("FAIL single_flit: wr=%b flit=%h, required 1/%h", bus.flit_wr, bus.flit_out, exp);
      end
      checks++;
      if (bus.dbg_credit[0] !== 3'd3 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL single_credit: credit0=%0d busy=%b, required 3/0", bus.dbg_credit[0], bus.busy);
      end
      @(negedge clk);
      checks++;
      if (bus.flit_wr !== 1'b0 || bus.flit_out !== exp || bus.ready !== 4'b1111) begin
         errors++;
         $display("FAIL single_hold: wr=%b flit=%h ready=%b, required 0/%h/1111",
                  bus.flit_wr, bus.flit_out, bus.ready, exp);
      end
   endtask

   task automatic test_back_to_back();
      flit_t       exp;
      logic [31:0] pay [4];
      pay = '{32'hFEF0_0D3A, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'hDEAD_BEEF};
      apply_reset();
      send_req(4'b0010, 6'd4, 4'h3, 64'hDEAD_BEEF_CAFE_F00D);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         exp = '{hdr_flag: (i == 0), tail_flag: (i == 3), vc: 4'b0010, payload: pay[i]};
         checks++;
         if (bus.flit_wr !== 1'b1 || bus.flit_out !== exp) begin
            errors++;
            $display("FAIL b2b_flit%0d: wr=%b flit=%h, required 1/%h", i, bus.flit_wr, bus.flit_out, exp);
         end
      end
      checks++;
      if (bus.dbg_credit[1] !== 3'd0 || bus.ready !== 4'b1101 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drained: credit1=%0d ready=%b busy=%b, required 0/1101/0",
                  bus.dbg_credit[1], bus.ready, bus.busy);
      end
      bus.credit_in = 4'b0010;
      @(negedge clk);
      bus.credit_in = 4'b0000;
      checks++;
      if (bus.ready !== 4'b1111 || bus.dbg_credit[1] !== 3'd1) begin
         errors++;
         $display("FAIL b2b_return: ready=%b credit1=%0d, required 1111/1", bus.ready, bus.dbg_credit[1]);
      end
   endtask

   task automatic test_stall();
      flit_t       exp;
      logic [31:0] pay [6];
      pay = '{32'h3344_447A, 32'h1111_2222, 32'h3333_4444, 32'h1111_2222, 32'h3333_4444, 32'h1111_2222};
      apply_reset();
      send_req(4'b0100, 6'd6, 4'h7, 64'h1111_2222_3333_4444);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         exp = '{hdr_flag: (i == 0), tail_flag: 1'b0, vc: 4'b0100, payload: pay[i]};
         checks++;
         if (bus.flit_wr !== 1'b1 || bus.flit_out !== exp) begin
            errors++;
            $display("FAIL stall_flit%0d: wr=%b flit=%h, required 1/%h", i, bus.flit_wr, bus.flit_out, exp);
         end
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (bus.flit_wr !== 1'b0 || bus.busy !== 1'b1 || bus.dbg_state !== BODY || bus.flit_out !== exp) begin
            errors++;
            $display("FAIL stall_wait%0d: wr=%b busy=%b state=%0d flit=%h, required 0/1/BODY/%h",
                     i, bus.flit_wr, bus.busy, bus.dbg_state, bus.flit_out, exp);
         end
      end
      bus.credit_in = 4'b0100;
      @(negedge clk);
      bus.credit_in = 4'b0000;
      exp = '{hdr_flag: 1'b0, tail_flag: 1'b0, vc: 4'b0100, payload: pay[4]};
      checks++;
      if (bus.flit_wr !== 1'b1 || bus.flit_out !== exp || bus.dbg_credit[2] !== 3'd0) begin
         errors++;
         $display("FAIL stall_pulse1: wr=%b flit=%h credit2=%0d, required 1/%h/0",
                  bus.flit_wr, bus.flit_out, bus.dbg_credit[2], exp);
      end
      @(negedge clk);
      checks++;
      if (bus.flit_wr !== 1'b0) begin
         errors++;
         $display("FAIL stall_gap: wr=%b, required 0", bus.flit_wr);
      end
      bus.credit_in = 4'b0100;
      @(negedge clk);
      bus.credit_in = 4'b0000;
      exp = '{hdr_flag: 1'b0, tail_flag: 1'b1, vc: 4'b0100, payload: pay[5]};
      checks++;
      if (bus.flit_wr !== 1'b1 || bus.flit_out !== exp) begin
         errors++;
         $display("FAIL stall_pulse2: wr=%b flit=%h, required 1/%h", bus.flit_wr, bus.flit_out, exp);
      end
      checks++;
      if (bus.dbg_state !== IDLE || bus.ready !== 4'b1011) begin
         errors++;
         $display("FAIL stall_end: state=%0d ready=%b, required IDLE/1011", bus.dbg_state, bus.ready);
      end
   endtask

   task automatic test_ignored_and_zero_size();
      flit_t exp;
      apply_reset();
      send_req(4'b0011, 6'd3, 4'h1, 64'hFFFF_FFFF_FFFF_FFFF);
      checks++;
      if (bus.busy !== 1'b0 || bus.dbg_state !== IDLE) begin
         errors++;
         $display("FAIL ignore_multi_vc: busy=%b state=%0d, required 0/IDLE", bus.busy, bus.dbg_state);
      end
      @(negedge clk);
      checks++;
      if (bus.flit_wr !== 1'b0 || bus.ready !== 4'b1111) begin
         errors++;
         $display("FAIL ignore_no_flit: wr=%b ready=%b, required 0/1111", bus.flit_wr, bus.ready);
      end
      send_req(4'b1000, 6'd0, 4'h2, 64'h0000_0000_00C0_FFEE);
      @(negedge clk);
      exp = '{hdr_flag: 1'b1, tail_flag: 1'b1, vc: 4'b1000, payload: 32'hC0FF_EE2A};
      checks++;
      if (bus.flit_wr !== 1'b1 || bus.flit_out !== exp) begin
         errors++;
         $display("FAIL zero_size_flit: wr=%b flit=%h, required 1/%h", bus.flit_wr, bus.flit_out, exp);
      end
      checks++;
      if (bus.dbg_credit[3] !== 3'd3 || bus.dbg_state !== IDLE) begin
         errors++;
         $display("FAIL zero_size_end: credit3=%0d state=%0d, required 3/IDLE", bus.dbg_credit[3], bus.dbg_state);
      end
   endtask

   // Oversize request clamps to 16 flits; a credit returns with every flit sent.
   task automatic test_same_cycle_credit();
      flit_t exp;
      apply_reset();
      send_req(4'b0001, 6'd20, 4'h9, 64'h0000_0001_0000_0002);
      bus.credit_in = 4'b0001;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (i == 15)
            bus.credit_in = 4'b0000;
         exp.hdr_flag  = (i == 0);
         exp.tail_flag = (i == 15);
         exp.vc        = 4'b0001;
         exp.payload   = (i == 0) ? 32'h0000_029A : ((i % 2) == 1) ? 32'h0000_0001 : 32'h0000_0002;
         checks++;
         if (bus.flit_wr !== 1'b1 || bus.flit_out !== exp) begin
            errors++;
            $display("FAIL same_cycle_flit%0d: wr=%b flit=%h, required 1/%h", i, bus.flit_wr, bus.flit_out, exp);
         end
         checks++;
         if (bus.dbg_credit[0] !== 3'd4) begin
            errors++;
            $display("FAIL same_cycle_credit%0d: got %0d, required 4", i, bus.dbg_credit[0]);
         end
      end
      @(negedge clk);
      checks++;
      if (bus.flit_wr !== 1'b0 || bus.dbg_state !== IDLE) begin
         errors++;
         $display("FAIL clamp_end: wr=%b state=%0d, required 0/IDLE", bus.flit_wr, bus.dbg_state);
      end
   endtask

   task automatic test_reset_mid_packet();
      flit_t exp;
      apply_reset();
      send_req(4'b0001, 6'd6, 4'h4, 64'h1111_2222_3333_4444);
      repeat (2) @(negedge clk);
      checks++;
      if (bus.flit_wr !== 1'b1 || bus.dbg_state !== BODY) begin
         errors++;
         $display("FAIL midrst_pre: wr=%b state=%0d, required 1/BODY", bus.flit_wr, bus.dbg_state);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (bus.flit_wr !== 1'b0 || bus.busy !== 1'b0 || bus.dbg_state !== IDLE) begin
         errors++;
         $display("FAIL midrst_outputs: wr=%b busy=%b state=%0d, required 0/0/IDLE",
                  bus.flit_wr, bus.busy, bus.dbg_state);
      end
      checks++;
      if (bus.dbg_credit[0] !== 3'd4) begin
         errors++;
         $display("FAIL midrst_credit: got %0d, required 4", bus.dbg_credit[0]);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      send_req(4'b0010, 6'd2, 4'h6, 64'hAAAA_BBBB_CCCC_DDDD);
      @(negedge clk);
      exp = '{hdr_flag: 1'b1, tail_flag: 1'b0, vc: 4'b0010, payload: 32'hCCDD_DD6A};
      checks++;
      if (bus.flit_wr !== 1'b1 || bus.flit_out !== exp) begin
         errors++;
         $display("FAIL midrst_new_hdr: wr=%b flit=%h, required 1/%h", bus.flit_wr, bus.flit_out, exp);
      end
      @(negedge clk);
      exp = '{hdr_flag: 1'b0, tail_flag: 1'b1, vc: 4'b0010, payload: 32'hAAAA_BBBB};
      checks++;
      if (bus.flit_wr !== 1'b1 || bus.flit_out !== exp) begin
         errors++;
         $display("FAIL midrst_new_tail: wr=%b flit=%h, required 1/%h", bus.flit_wr, bus.flit_out, exp);
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single_flit();
      test_back_to_back();
      test_stall();
      test_ignored_and_zero_size();
      test_same_cycle_credit();
      test_reset_mid_packet();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
